instr_encoder: RTL
==================

# instr_encoder

Packs symbolic instruction fields into the 9-bit machine words that the control decoder consumes, then writes them sequentially into instruction memory. It is the writer/encoder end of the instruction format: the program loader (testbench or host shim) feeds one instruction per handshake, and this block validates, encodes, and streams words into the instruction-memory write port. It is used at load time, before the core is released from reset.

## Interface
- AW, 10: instruction-memory address width; capacity 2**AW words.
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; begins or restarts a load session at address 0.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  block can accept a bundle this cycle.
- in_op  input  3  opcode.
- in_mode  input  4  mode field.
- in_ra  input  3  first register.
- in_rb  input  3  second register.
- in_imm  input  4  signed immediate (AddI only).
- in_last  input  1  bundle is the final instruction of the program.
- im_we  output  1  instruction-memory write strobe.
- im_addr  output  AW  write address.
- im_data  output  9  encoded word.
- word_count  output  AW+1  words written this session.
- err  output  1  sticky: at least one illegal bundle was dropped this session.
- done  output  1  session complete (last accepted, or memory full).

## Operation
- Encoding, im_data[8:6] = in_op; im_data[5:0] by opcode:
  - 000 ADD, 001 XOR, 010 AND: {ra, rb}.
  - 011 LOD/STO: {ra[1:0], mode[3], rb}; illegal if ra[2]=1.
  - 100 AddI: {ra[1:0], imm}; illegal if ra[2]=0.
  - 101 Shift: {ra, mode[2:0]}; mode[2:0] must be 000, 010, 011, 100 or 110.
  - 110 Branch: {ra, mode[2:0]}; all modes legal.
  - 111 Parity: {3'b000, mode[2:0]}; illegal if ra != 0.
- Unused input fields for an opcode are ignored.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: in_ready=0. start -> LOAD.
  - LOAD: in_ready=1 unless accepted-legal count = 2**AW. Accept = in_valid & in_ready.
  - Legal accept: register word, pulse im_we next cycle, increment address after the write.
  - Illegal accept: no write, address unchanged, err set.
  - Accept with in_last (legal or illegal) -> DONE.
  - The 2**AW-th legal accept -> DONE even without in_last.
  - DONE: in_ready=0, done=1; holds until start.
- start in any state: address=0, word_count=0, err=0, done=0, state=LOAD. A write pending from the previous cycle still completes at its old address. A bundle presented in the same cycle as start is not accepted.
- word_count counts completed writes; saturates at 2**AW.

## Timing
- Reset (Reset=0 at edge): state IDLE, in_ready=0, im_we=0, im_addr=0, im_data=0, word_count=0, err=0, done=0. Reset mid-session drops any pending write.
- Latency: bundle accepted at edge N produces im_we=1 with im_addr/im_data stable for the cycle after edge N, so the memory writes at edge N+1.
- Throughput: one bundle per cycle; back-to-back accepts give consecutive addresses with im_we held high.
- in_ready depends only on registered state, never on in_valid.
- done and the DONE transition take effect at the edge that accepts the final bundle. The final write is visible in the following cycle, concurrently with done=1.
- im_addr wraps to 0 after the last write at 2**AW-1; no further writes occur, because in_ready is 0.

## Test plan
- Reset, start, then ADD ra=3 rb=5 -> next cycle im_we=1, im_addr=0, im_data=9'h01D; word_count=1.
- Back-to-back: STO ra=1 mode=1000 rb=2, then AddI ra=6 imm=1110, then Branch ra=4 mode=101 (in_last) -> words 9'h0DA, 9'h12E, 9'h1A5 at addresses 0, 1, 2; done=1; err=0.
- Illegal inputs:
  - Shift ra=2 mode=001 -> no im_we, err=1, address unchanged.
  - Following Parity ra=0 mode=011 -> 9'h1C3 written at the same address.
- Fill with AW=2: five ADD bundles -> four writes at addresses 0-3; in_ready=0 after the fourth accept; done=1; word_count=4.
- Assert Reset during LOAD with a pending write -> no im_we the next cycle; all outputs at reset values.
- Pulse start during DONE -> word_count=0, err=0, done=0; the next legal bundle writes address 0.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction-memory loader: validates symbolic instruction bundles, packs them
// into 9-bit words and streams them into sequential instruction-memory addresses.
module instr_encoder #(
    parameter int AW = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [3:0]    in_mode,
    input  logic [2:0]    in_ra,
    input  logic [2:0]    in_rb,
    input  logic [3:0]    in_imm,
    input  logic          in_last,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [8:0]    im_data,
    output logic [AW:0]   word_count,
    output logic          err,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_LAST  = {1'b0, {AW{1'b1}}};
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    function automatic logic is_legal(input logic [2:0] op, input logic [3:0] mode,
                                      input logic [2:0] ra);
        logic ok;
        ok = 1'b1;
        case (op)
            3'b011:  ok = ~ra[2];
            3'b100:  ok = ra[2];
            3'b101: begin
                case (mode[2:0])
                    3'b000, 3'b010, 3'b011, 3'b100, 3'b110: ok = 1'b1;
                    default:                                ok = 1'b0;
                endcase
            end
            3'b111:  ok = (ra == 3'b000);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [8:0] encode(input logic [2:0] op, input logic [3:0] mode,
                                          input logic [2:0] ra, input logic [2:0] rb,
                                          input logic [3:0] imm);
        logic [5:0] f;
        case (op)
            3'b000, 3'b001, 3'b010: f = {ra, rb};
            3'b011:                 f = {ra[1:0], mode[3], rb};
            3'b100:                 f = {ra[1:0], imm};
            3'b101, 3'b110:         f = {ra, mode[2:0]};
            3'b111:                 f = {3'b000, mode[2:0]};
            default:                f = 6'b000000;
        endcase
        return {op, f};
    endfunction

    state_t        state_r;
    state_t        state_nxt_s;
    logic          ready_r;
    logic          done_r;
    logic          err_r;
    logic          im_we_r;
    logic [AW-1:0] im_addr_r;
    logic [8:0]    im_data_r;
    logic [AW:0]   word_count_r;
    logic [AW:0]   acc_cnt_r;
    logic [AW:0]   acc_cnt_nxt_s;
    logic          accept_s;
    logic          legal_s;

    // A bundle offered alongside start belongs to no session and is ignored.
    assign accept_s = in_valid & ready_r & ~start;
    assign legal_s  = is_legal(in_op, in_mode, in_ra);

    // Next-state and next legal-accept count.
    always_comb begin
        state_nxt_s   = state_r;
        acc_cnt_nxt_s = acc_cnt_r;
        if (start) begin
            state_nxt_s   = LOAD;
            acc_cnt_nxt_s = CNT_ZERO;
        end else begin
            if (accept_s && legal_s) begin
                acc_cnt_nxt_s = acc_cnt_r + CNT_ONE;
            end else begin
                acc_cnt_nxt_s = acc_cnt_r;
            end
            case (state_r)
                IDLE: state_nxt_s = IDLE;
                LOAD: begin
                    if (accept_s && (in_last || (legal_s && (acc_cnt_r == CNT_LAST)))) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = LOAD;
                    end
                end
                DONE:    state_nxt_s = DONE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Write port, session counters and status flags; im_addr advances once a write lands.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ready_r      <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            im_we_r      <= 1'b0;
            im_addr_r    <= ADDR_ZERO;
            im_data_r    <= 9'h000;
            word_count_r <= CNT_ZERO;
            acc_cnt_r    <= CNT_ZERO;
        end else begin
            ready_r   <= (state_nxt_s == LOAD) && (acc_cnt_nxt_s != CNT_FULL);
            done_r    <= (state_nxt_s == DONE);
            im_we_r   <= accept_s & legal_s;
            acc_cnt_r <= acc_cnt_nxt_s;
            if (accept_s && legal_s) begin
                im_data_r <= encode(in_op, in_mode, in_ra, in_rb, in_imm);
            end
            if (start) begin
                im_addr_r    <= ADDR_ZERO;
                word_count_r <= CNT_ZERO;
                err_r        <= 1'b0;
            end else begin
                if (im_we_r) begin
                    im_addr_r <= im_addr_r + ADDR_ONE;
                end
                if (im_we_r && (word_count_r != CNT_FULL)) begin
                    word_count_r <= word_count_r + CNT_ONE;
                end
                if (accept_s && !legal_s) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    assign in_ready   = ready_r;
    assign done       = done_r;
    assign err        = err_r;
    assign im_we      = im_we_r;
    assign im_addr    = im_addr_r;
    assign im_data    = im_data_r;
    assign word_count = word_count_r;

endmodule
